// File: rtl/tri_bus_arbiter4_if.sv
// Bus-side signal bundle for the 4-source tristate bus arbiter.
// The master modport is the arbiter view. The slave modport is the requester view.
interface tri_bus_arbiter4_if;
  logic [3:0] req;
  logic [3:0] done;
  logic [3:0] gnt;
  logic [1:0] sel;
  logic       bus_en;
  logic       timeout;

  modport master (
    input  req,
    input  done,
    output gnt,
    output sel,
    output bus_en,
    output timeout
  );

  modport slave (
    output req,
    output done,
    input  gnt,
    input  sel,
    input  bus_en,
    input  timeout
  );
endinterface

// File: rtl/tri_bus_arbiter4.sv
// Round-robin owner sequencer for a 4-source bufif1 shared bus.
// At most one driver is enabled at a time, and each tenure is followed by
// idle turnaround cycles so that two drivers never overlap.
// Each tenure is capped at HOLD_MAX cycles so a stuck requester cannot hog the bus.
// Every output comes from a flop. No combinational path exists from req/done to any output.
module tri_bus_arbiter4 #(
  parameter int HOLD_MAX = 16,
  parameter int TURN_CYC = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  tri_bus_arbiter4_if.master   bus
);

  localparam int HC_W = $clog2(HOLD_MAX + 1);
  localparam int TC_W = $clog2(TURN_CYC + 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_GRANT = 2'd1,
    ST_TURN  = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [3:0]      gnt_q, gnt_d;
  logic [1:0]      sel_q, sel_d;
  logic [1:0]      last_q, last_d;
  logic            bus_en_q, bus_en_d;
  logic            timeout_q, timeout_d;
  logic [HC_W-1:0] hold_cnt_q, hold_cnt_d;
  logic [TC_W-1:0] turn_cnt_q, turn_cnt_d;
  logic [1:0]      win_s;
  logic            end_rel_s;
  logic            end_hold_s;

  // The winner is the first set request bit found by scanning from last+1, wrapping modulo 4.
  function automatic logic [1:0] rr_pick(input logic [3:0] r, input logic [1:0] last);
    logic [1:0] idx;
    logic       found;
    rr_pick = last;
    found   = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      idx = last + 2'(i);
      if (!found && r[idx]) begin
        rr_pick = idx;
        found   = 1'b1;
      end else begin
        found = found;
      end
    end
  endfunction

  function automatic logic [3:0] onehot4(input logic [1:0] idx);
    onehot4 = 4'b0001 << idx;
  endfunction

  // Next-state and next-output computation for the IDLE/GRANT/TURN sequencer.
  always_comb begin
    state_d    = state_q;
    gnt_d      = gnt_q;
    sel_d      = sel_q;
    last_d     = last_q;
    hold_cnt_d = hold_cnt_q;
    turn_cnt_d = turn_cnt_q;
    timeout_d  = 1'b0;
    win_s      = rr_pick(bus.req, last_q);
    end_rel_s  = 1'b0;
    end_hold_s = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (bus.req != 4'b0000) begin
          gnt_d      = onehot4(win_s);
          sel_d      = win_s;
          last_d     = win_s;
          hold_cnt_d = HC_W'(1);
          state_d    = ST_GRANT;
        end else begin
          gnt_d   = 4'b0000;
          state_d = ST_IDLE;
        end
      end
      ST_GRANT: begin
        // Only the current owner's done/req bits can end the tenure.
        end_rel_s  = bus.done[sel_q] | ~bus.req[sel_q];
        end_hold_s = (hold_cnt_q == HC_W'(HOLD_MAX));
        if (end_rel_s || end_hold_s) begin
          gnt_d      = 4'b0000;
          turn_cnt_d = TC_W'(1);
          timeout_d  = end_hold_s & ~end_rel_s;
          state_d    = ST_TURN;
        end else if (hold_cnt_q != HC_W'(HOLD_MAX)) begin
          hold_cnt_d = hold_cnt_q + HC_W'(1);
        end else begin
          hold_cnt_d = hold_cnt_q;
        end
      end
      ST_TURN: begin
        gnt_d = 4'b0000;
        if (turn_cnt_q >= TC_W'(TURN_CYC)) begin
          state_d = ST_IDLE;
        end else begin
          turn_cnt_d = turn_cnt_q + TC_W'(1);
        end
      end
      default: begin
        gnt_d   = 4'b0000;
        state_d = ST_IDLE;
      end
    endcase
    bus_en_d = |gnt_d;
  end

  // State and output registers. Reset drops every driver enable immediately.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      gnt_q      <= 4'b0000;
      sel_q      <= 2'd0;
      last_q     <= 2'd3;
      bus_en_q   <= 1'b0;
      timeout_q  <= 1'b0;
      hold_cnt_q <= '0;
      turn_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      gnt_q      <= gnt_d;
      sel_q      <= sel_d;
      last_q     <= last_d;
      bus_en_q   <= bus_en_d;
      timeout_q  <= timeout_d;
      hold_cnt_q <= hold_cnt_d;
      turn_cnt_q <= turn_cnt_d;
    end
  end

  assign bus.gnt     = gnt_q;
  assign bus.sel     = sel_q;
  assign bus.bus_en  = bus_en_q;
  assign bus.timeout = timeout_q;

endmodule

// File: tb/tb_tri_bus_arbiter4.sv
// Directed and random bench for tri_bus_arbiter4.
// Expected grants are queued as stimulus is applied and are compared when a grant appears.
module tb_tri_bus_arbiter4;

  logic clk;
  logic rst;
  int   checks;
  int   failures;
  logic [3:0] exp_q[$];

  tri_bus_arbiter4_if bus ();

  tri_bus_arbiter4 #(.HOLD_MAX(16), .TURN_CYC(1)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Waits (bounded) for a grant, then compares it against the head of the queue.
  task automatic wait_grant(input string tag, output int zeros);
    logic [3:0] exp;
    zeros = 0;
    while (bus.gnt == 4'b0000 && zeros < 20) begin
      zeros++;
      tick();
    end
    if (exp_q.size() == 0) begin
      exp = 4'bxxxx;
    end else begin
      exp = exp_q.pop_front();
    end
    check(tag, {28'd0, bus.gnt}, {28'd0, exp});
  endtask

  initial begin
    int z;
    int cnt;
    int zero_run;
    logic [3:0] prev_gnt;
    checks   = 0;
    failures = 0;
    rst      = 1'b1;
    bus.req  = 4'b1111;
    bus.done = 4'b0000;
    tick();
    tick();
    check("rst_gnt", {28'd0, bus.gnt}, 32'd0);
    check("rst_sel", {30'd0, bus.sel}, 32'd0);
    check("rst_bus_en", {31'd0, bus.bus_en}, 32'd0);
    check("rst_timeout", {31'd0, bus.timeout}, 32'd0);

    // Test 1: round robin with every source requesting.
    exp_q.push_back(4'b0001);
    exp_q.push_back(4'b0010);
    exp_q.push_back(4'b0100);
    exp_q.push_back(4'b1000);
    exp_q.push_back(4'b0001);
    rst = 1'b0;
    wait_grant("rr_first", z);
    check("rr_first_latency", z, 32'd1);
    check("rr_first_sel", {30'd0, bus.sel}, 32'd0);
    for (int i = 0; i < 4; i++) begin
      bus.done = bus.gnt;
      tick();
      bus.done = 4'b0000;
      check("rr_release_gnt", {28'd0, bus.gnt}, 32'd0);
      check("rr_release_timeout", {31'd0, bus.timeout}, 32'd0);
      wait_grant("rr_grant", z);
      check("rr_gap", z, 32'd2);
      check("rr_bus_en", {31'd0, bus.bus_en}, 32'd1);
      check("rr_sel", {30'd0, bus.sel}, (i + 1) % 4);
    end

    // Test 2: sole requester that never releases runs into the hold cap.
    bus.req = 4'b0100;
    tick();
    exp_q.push_back(4'b0100);
    wait_grant("hold_grant", z);
    cnt = 0;
    while (bus.gnt == 4'b0100 && cnt < 40) begin
      cnt++;
      tick();
    end
    check("hold_len", cnt, 32'd16);
    check("hold_timeout_pulse", {31'd0, bus.timeout}, 32'd1);
    exp_q.push_back(4'b0100);
    wait_grant("hold_regrant", z);
    check("hold_gap", z, 32'd2);
    check("hold_timeout_clear", {31'd0, bus.timeout}, 32'd0);

    // Test 3: owner 1 drops its request while sources 2 and 3 are waiting.
    bus.req = 4'b0010;
    tick();
    exp_q.push_back(4'b0010);
    wait_grant("drop_own1", z);
    bus.req = 4'b1110;
    tick();
    tick();
    check("drop_keep1", {28'd0, bus.gnt}, 32'd2);
    bus.req = 4'b1100;
    tick();
    exp_q.push_back(4'b0100);
    wait_grant("drop_next2", z);
    check("drop_sel2", {30'd0, bus.sel}, 32'd2);
    bus.done = 4'b0100;
    tick();
    bus.done = 4'b0000;
    exp_q.push_back(4'b1000);
    wait_grant("drop_next3", z);
    check("drop_sel3", {30'd0, bus.sel}, 32'd3);

    // Test 4: a done pulse from a non-owner is ignored.
    bus.req = 4'b0001;
    tick();
    exp_q.push_back(4'b0001);
    wait_grant("ign_own0", z);
    bus.done = 4'b1000;
    tick();
    bus.done = 4'b0000;
    check("ign_gnt", {28'd0, bus.gnt}, 32'd1);
    check("ign_timeout", {31'd0, bus.timeout}, 32'd0);
    tick();
    check("ign_gnt_later", {28'd0, bus.gnt}, 32'd1);

    // Test 5: asynchronous reset in the middle of a tenure.
    bus.req = 4'b0010;
    tick();
    exp_q.push_back(4'b0010);
    wait_grant("arst_own1", z);
    rst = 1'b1;
    #1;
    check("arst_gnt", {28'd0, bus.gnt}, 32'd0);
    check("arst_bus_en", {31'd0, bus.bus_en}, 32'd0);
    check("arst_sel", {30'd0, bus.sel}, 32'd0);
    bus.req = 4'b0011;
    tick();
    tick();
    rst = 1'b0;
    exp_q.push_back(4'b0001);
    wait_grant("arst_first", z);

    // Test 6: random traffic with invariant checks every cycle.
    prev_gnt = bus.gnt;
    zero_run = 0;
    for (int i = 0; i < 10000; i++) begin
      bus.req  = 4'($urandom);
      bus.done = ($urandom_range(0, 5) == 0) ? 4'($urandom) : 4'b0000;
      tick();
      check("rand_onehot0", {31'd0, $onehot0(bus.gnt)}, 32'd1);
      check("rand_bus_en", {31'd0, bus.bus_en}, {31'd0, |bus.gnt});
      if (bus.gnt != 4'b0000 && prev_gnt == 4'b0000) begin
        check("rand_gap", {31'd0, zero_run >= 2}, 32'd1);
      end else if (bus.gnt != 4'b0000) begin
        check("rand_no_handover", {28'd0, bus.gnt}, {28'd0, prev_gnt});
      end else begin
        zero_run = zero_run;
      end
      zero_run = (bus.gnt == 4'b0000) ? zero_run + 1 : 0;
      prev_gnt = bus.gnt;
    end

    check("queue_drained", exp_q.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
